// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder for the datapath load/store port.
// One read or write per transaction, with a fixed configurable response latency.
module data_mem_responder #(
  parameter int NBITS       = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 2**(NBITS-2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:2] Address,
  input  logic [NBITS-1:0] WriteData,
  output logic [NBITS-1:0] ReadData,
  output logic             Ready,
  output logic             Busy,
  output logic             Err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [NBITS-1:2] lat_addr;
  logic [NBITS-1:0] lat_data;
  logic             lat_write;
  logic [NBITS-1:0] mem [DEPTH];

  logic             accept;
  logic             illegal;
  logic             load_rd;
  logic             commit;
  logic [NBITS-1:2] rd_addr;

  assign accept  = (state == S_IDLE) && (MemRead ^ MemWrite);
  assign illegal = (state == S_IDLE) && MemRead && MemWrite;
  assign commit  = (state == S_RESP) && lat_write;
  assign Busy    = (state != S_IDLE);

  // With zero wait cycles RESP is entered straight from IDLE, before the
  // request has been latched, so the load address comes from the port.
  assign rd_addr = (state == S_IDLE) ? Address : lat_addr;
  assign load_rd = (state_nxt == S_RESP) &&
                   ((state == S_IDLE) ? MemRead : !lat_write);

  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_nxt   = 4'(WAIT_CYCLES);
          state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
      ReadData  <= '0;
      Ready     <= 1'b0;
      Err       <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_addr  <= Address;
        lat_data  <= WriteData;
        lat_write <= MemWrite;
      end
      if (load_rd) ReadData <= mem[rd_addr];
      Ready <= (state_nxt == S_RESP);
      Err   <= illegal;
    end
  end

  // NOTE: the array must read as all-zero after reset, so it is built from
  // resettable flops rather than a RAM macro that has no reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[lat_addr] <= lat_data;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder; two instances
// (two wait cycles and zero wait cycles) share the stimulus.
module tb_data_mem_responder;

  localparam int NBITS = 8;
  localparam int NW    = 2**(NBITS-2);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             MemRead = 1'b0;
  logic             MemWrite = 1'b0;
  logic [NBITS-1:2] Address = '0;
  logic [NBITS-1:0] WriteData = '0;

  logic [NBITS-1:0] rdata_a, rdata_b;
  logic             ready_a, ready_b, busy_a, busy_b, err_a, err_b;

  data_mem_responder #(.NBITS(NBITS), .WAIT_CYCLES(2)) dut_a (
    .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(rdata_a),
    .Ready(ready_a), .Busy(busy_a), .Err(err_a)
  );

  data_mem_responder #(.NBITS(NBITS), .WAIT_CYCLES(0)) dut_b (
    .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(rdata_b),
    .Ready(ready_b), .Busy(busy_b), .Err(err_b)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each transaction is a scheduled response cycle.
  int             t;
  int             lat     [2] = '{2, 0};
  int             resp_at [2];
  int             err_at  [2];
  bit             op_wr   [2];
  int             m_addr  [2];
  logic [7:0]     m_data  [2];
  logic [7:0]     rd_m    [2];
  logic [7:0]     mem_m   [2][NW];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      resp_at[d] = -1;
      err_at[d]  = -1;
      rd_m[d]    = 8'h00;
      for (int i = 0; i < NW; i++) mem_m[d][i] = 8'h00;
    end
  endtask

  task automatic check_cycle();
    logic [7:0] o_rd;
    logic       o_ready, o_busy, o_err;
    for (int d = 0; d < 2; d++) begin
      if (t == resp_at[d] && !op_wr[d]) rd_m[d] = mem_m[d][m_addr[d]];
      o_rd    = (d == 0) ? rdata_a : rdata_b;
      o_ready = (d == 0) ? ready_a : ready_b;
      o_busy  = (d == 0) ? busy_a  : busy_b;
      o_err   = (d == 0) ? err_a   : err_b;
      check($sformatf("busy%0d", d),  32'(o_busy),  32'(resp_at[d] >= 0));
      check($sformatf("ready%0d", d), 32'(o_ready), 32'(t == resp_at[d]));
      check($sformatf("err%0d", d),   32'(o_err),   32'(t == err_at[d]));
      check($sformatf("rdata%0d", d), 32'(o_rd),    32'(rd_m[d]));
    end
  endtask

  task automatic step(input bit rd, input bit wr, input int addr, input logic [7:0] data);
    bit idle;
    check_cycle();
    for (int d = 0; d < 2; d++) begin
      idle = (resp_at[d] < 0);
      if (resp_at[d] == t) begin
        if (op_wr[d]) mem_m[d][m_addr[d]] = m_data[d];
        resp_at[d] = -1;
      end
      if (idle && (rd ^ wr)) begin
        resp_at[d] = t + 1 + lat[d];
        op_wr[d]   = wr;
        m_addr[d]  = addr;
        m_data[d]  = data;
      end else if (idle && rd && wr) begin
        err_at[d] = t + 1;
      end
    end
    MemRead   = rd;
    MemWrite  = wr;
    Address   = 6'(addr);
    WriteData = data;
    @(negedge clock);
    t++;
  endtask

  // One request followed by enough idle cycles for both instances to finish.
  task automatic xact(input bit rd, input bit wr, input int addr, input logic [7:0] data);
    step(rd, wr, addr, data);
    repeat (3) step(1'b0, 1'b0, 0, 8'h00);
  endtask

  task automatic reset_pulse();
    check_cycle();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_busy_a",  32'(busy_a),  32'd0);
    check("rst_busy_b",  32'(busy_b),  32'd0);
    check("rst_ready_a", 32'(ready_a), 32'd0);
    check("rst_ready_b", 32'(ready_b), 32'd0);
    check("rst_rdata_a", 32'(rdata_a), 32'd0);
    check("rst_rdata_b", 32'(rdata_b), 32'd0);
    model_reset();
    @(negedge clock);
    t++;
    reset = 1'b1;
  endtask

  initial begin
    bit         rd, wr;
    int         r, addr;
    logic [7:0] data;

    model_reset();
    t = 0;
    @(negedge clock);
    check("init_busy_a",  32'(busy_a),  32'd0);
    check("init_ready_a", 32'(ready_a), 32'd0);
    check("init_err_a",   32'(err_a),   32'd0);
    check("init_rdata_b", 32'(rdata_b), 32'd0);
    reset = 1'b1;

    // Read of a never-written word after reset.
    xact(1'b1, 1'b0, 5, 8'h00);
    check("rd5_a", 32'(rdata_a), 32'h00);

    // Write then read back; a neighbouring word stays zero.
    xact(1'b0, 1'b1, 3, 8'hA5);
    xact(1'b1, 1'b0, 3, 8'h00);
    check("rd3_a", 32'(rdata_a), 32'hA5);
    check("rd3_b", 32'(rdata_b), 32'hA5);
    xact(1'b1, 1'b0, 4, 8'h00);
    check("rd4_a", 32'(rdata_a), 32'h00);

    // Top word of the array.
    xact(1'b0, 1'b1, 63, 8'h3C);
    xact(1'b1, 1'b0, 63, 8'h00);
    check("rd63_a", 32'(rdata_a), 32'h3C);
    check("rd63_b", 32'(rdata_b), 32'h3C);

    // Illegal request performs no access.
    xact(1'b1, 1'b1, 7, 8'hFF);
    xact(1'b1, 1'b0, 7, 8'h00);
    check("rd7_a", 32'(rdata_a), 32'h00);
    check("rd7_b", 32'(rdata_b), 32'h00);

    // A write driven while a read is in flight must be ignored.
    xact(1'b0, 1'b1, 1, 8'h11);
    step(1'b1, 1'b0, 1, 8'h00);
    step(1'b0, 1'b1, 1, 8'h99);
    repeat (2) step(1'b0, 1'b0, 0, 8'h00);
    check("rd1_a", 32'(rdata_a), 32'h11);
    xact(1'b1, 1'b0, 1, 8'h00);
    check("rd1again_a", 32'(rdata_a), 32'h11);
    check("rd1again_b", 32'(rdata_b), 32'h11);

    // Reset while a write is pending aborts it.
    step(1'b0, 1'b1, 9, 8'h77);
    reset_pulse();
    xact(1'b1, 1'b0, 9, 8'h00);
    check("rd9_a", 32'(rdata_a), 32'h00);
    check("rd9_b", 32'(rdata_b), 32'h00);

    // Random traffic, concentrated on a few addresses to hit read-after-write.
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 3) || (r == 6);
      wr = (r >= 3 && r < 7);
      addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NW-1))
                                         : int'($urandom_range(0, 7));
      data = 8'($urandom);
      if (i == 200) reset_pulse();
      else step(rd, wr, addr, data);
    end
    repeat (4) step(1'b0, 1'b0, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder on the far end of the datapath's load/store interface (Address[NBITS-1:2], WriteData, ReadData).
- Accepts one word read or write per transaction and models a configurable access latency.
- Drives Busy to stall the core, pulses Ready on completion, and flags illegal requests.
- Word-addressed internal array with one entry per Address value.

Parameters:
NBITS, 8, data width; also sets address width (Address is NBITS-2 bits)
WAIT_CYCLES, 2, extra wait cycles between acceptance and response (0 legal, max 15)
DEPTH, 2**(NBITS-2), number of words in the array

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
MemRead  input  1  read request, sampled only in IDLE
MemWrite  input  1  write request, sampled only in IDLE
Address  input  [NBITS-1:2]  word address of request
WriteData  input  NBITS  store data, sampled with MemWrite
ReadData  output  NBITS  registered load data
Ready  output  1  one-cycle completion pulse
Busy  output  1  high while a transaction is in flight (state != IDLE)
Err  output  1  one-cycle pulse on an illegal request

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE and the wait counter clears.
  - ReadData=0, Ready=0, Busy=0, Err=0.
  - All DEPTH array words clear to 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE, at a rising edge:
  - Exactly one of MemRead/MemWrite high: latch Address, WriteData and the op. Load cnt=WAIT_CYCLES. Go to WAIT, or straight to RESP if WAIT_CYCLES=0.
  - Both high: no access and no state change; Err=1 in the next cycle only.
  - Neither high: stay in IDLE.
- WAIT:
  - cnt decrements each edge.
  - When cnt==1 at an edge, go to RESP.
  - MemRead, MemWrite, Address and WriteData are ignored; only the latched copies are used.
- RESP (exactly one cycle):
  - Ready=1.
  - Latched read: ReadData shows array[latched address]. It is loaded on the edge that enters RESP and held until the next read's RESP; writes and IDLE do not change it.
  - Latched write: array[latched address] <= latched WriteData on the edge leaving RESP.
  - Always returns to IDLE.
- Latency: a request held high in cycle c gives Ready=1 in cycle c+1+WAIT_CYCLES.
- Busy = (state != IDLE); it is combinational from the state register and high in WAIT and RESP.
- A request in the RESP cycle is not accepted. Minimum spacing between acceptances is WAIT_CYCLES+2 cycles.
- Read-after-write to the same address returns the new value: the write commits before the next IDLE sample.
- Reset asserted in WAIT or RESP aborts the transaction. A pending write is not committed, Ready is not pulsed, and Busy drops asynchronously.
- Address always lies within 0..DEPTH-1, so there is no out-of-range case. The array is indexed by Address directly, with no wrap logic.
- Ready and Err never assert in the same cycle. Err only occurs from IDLE; Ready only in RESP.
- Outputs are glitch-free registered values except Busy, which is decoded from the state register only.

Test Plan:
- Reset then read: release reset, MemRead=1, Address=5, WAIT_CYCLES=2 -> Busy=1 for 3 cycles, Ready=1 in cycle c+3, ReadData=0x00.
- Write then read back: write Address=3, WriteData=0xA5, wait for Ready, then read Address=3 -> second Ready with ReadData=0xA5. A read of Address=4 returns 0x00.
- Zero latency (WAIT_CYCLES=0): write 0x3C to Address=63, then read it -> each Ready in cycle c+1, Busy high 1 cycle each, ReadData=0x3C (top word, no wrap).
- Illegal request: MemRead=MemWrite=1, Address=7, WriteData=0xFF -> Err=1 for one cycle, Busy=0, no Ready. A subsequent read of Address 7 returns 0x00.
- Inputs ignored while busy: accept a read of Address=1 holding 0x11, then drive MemWrite=1, Address=1, WriteData=0x99 during WAIT -> only one Ready, ReadData=0x11, and a later read of Address=1 still returns 0x11.
- Reset mid-write: accept a write of 0x77 to Address=9, assert reset during WAIT -> Busy, Ready and ReadData all 0 immediately, and after release a read of Address=9 returns 0x00.
